// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the execute
// stage (requester 0) and the branch/address-compare unit (requester 1).
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_aluc,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_r,
  output logic [3:0]       rsp0_flags,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_aluc,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_r,
  output logic [3:0]       rsp1_flags,
  output logic             alu_ctr,
  output logic [3:0]       alu_aluc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [3:0]       aluc_q, aluc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [3:0]       flags_q, flags_d;
  logic             ctr_q, ctr_d;
  logic             busy_q, busy_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             any_req;
  logic             grant;

  // Requester 1 wins only when alone or when requester 0 was served last.
  assign any_req    = req0_valid | req1_valid;
  assign grant      = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = (state_q == IDLE) & req0_valid & ~grant;
  assign req1_ready = (state_q == IDLE) & grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    aluc_d       = aluc_q;
    a_d          = a_q;
    b_d          = b_q;
    r_d          = r_q;
    flags_d      = flags_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          aluc_d       = grant ? req1_aluc : req0_aluc;
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          owner_d      = grant;
          last_grant_d = grant;
          lat_cnt_d    = LAT_INIT;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_cnt_q != 3'd0) begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end else begin
          r_d     = alu_r;
          flags_d = {alu_zero, alu_carry, alu_negative, alu_overflow};
          state_d = RESP;
        end
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they align with it.
    ctr_d        = (state_d == ISSUE);
    busy_d       = (state_d != IDLE);
    rsp0_valid_d = (state_d == RESP) & ~owner_d;
    rsp1_valid_d = (state_d == RESP) & owner_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      lat_cnt_q    <= 3'd0;
      aluc_q       <= 4'd0;
      a_q          <= '0;
      b_q          <= '0;
      r_q          <= '0;
      flags_q      <= 4'd0;
      ctr_q        <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      aluc_q       <= aluc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      r_q          <= r_d;
      flags_q      <= flags_d;
      ctr_q        <= ctr_d;
      busy_q       <= busy_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign alu_ctr    = ctr_q;
  assign alu_aluc   = aluc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = busy_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_r     = r_q;
  assign rsp1_r     = r_q;
  assign rsp0_flags = flags_q;
  assign rsp1_flags = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, cycle-level arbitration model and a
// response scoreboard checked by an independent monitor.
module tb_alu_arbiter;
  localparam int LAT = 3;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [3:0]  req0_aluc, rsp0_flags;
  logic [31:0] req0_a, req0_b, rsp0_r;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [3:0]  req1_aluc, rsp1_flags;
  logic [31:0] req1_a, req1_b, rsp1_r;
  logic        alu_ctr, busy;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_a, alu_b, alu_r;
  logic        alu_zero, alu_carry, alu_negative, alu_overflow;
  logic [35:0] alu_out;

  typedef struct { bit owner; logic [31:0] r; logic [3:0] f; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter #(.WIDTH(32), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluc(req0_aluc),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_r(rsp0_r), .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluc(req1_aluc),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r), .rsp1_flags(rsp1_flags),
    .alu_ctr(alu_ctr), .alu_aluc(alu_aluc), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow), .busy(busy)
  );

  // Behavioural ALU: returns {r, zero, carry, negative, overflow}.
  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0; r = '0;
    case (op)
      4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
      4'b0010: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                     v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0001: begin r = a - b; c = (a < b); end
      4'b0011: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1000, 4'b1001: r = {b[15:0], 16'h0000};
      4'b1011: r = {31'd0, ($signed(a) < $signed(b))};
      4'b1010: r = {31'd0, (a < b)};
      4'b1100: r = $signed(b) >>> a[4:0];
      4'b1101: r = b >> a[4:0];
      default: r = b << a[4:0];
    endcase
    return {r, (r == 32'd0), c, r[31], v};
  endfunction

  // Outside ctr the ALU shows junk so any capture outside ISSUE is visible.
  assign alu_out      = alu_f(alu_aluc, alu_a, alu_b);
  assign alu_r        = alu_ctr ? alu_out[35:4] : 32'hDEADBEEF;
  assign alu_zero     = alu_ctr ? alu_out[3] : 1'b1;
  assign alu_carry    = alu_ctr ? alu_out[2] : 1'b0;
  assign alu_negative = alu_ctr ? alu_out[1] : 1'b1;
  assign alu_overflow = alu_ctr ? alu_out[0] : 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Arbitration/timing model: phase 0 idle, 1 ALU issue, 2 awaiting consumer.
  int          m_phase = 0;
  int          m_cnt = 0;
  bit          m_last = 1'b1;
  bit          m_owner = 1'b0;
  logic [3:0]  m_aluc;
  logic [31:0] m_a, m_b;

  always @(negedge clk) begin
    bit e0, e1;
    exp_t e;
    if (!rst_n) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_ctr", alu_ctr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("rst_alu_ops", {alu_aluc, alu_a, alu_b}, 0);
      m_phase = 0; m_last = 1'b1;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          e0 = req0_valid && (!req1_valid || m_last);
          e1 = req1_valid && !e0;
          chk("grant0", req0_ready, e0);
          chk("grant1", req1_ready, e1);
          chk("idle_ctr", alu_ctr, 0);
          chk("idle_busy", busy, 0);
          if (e0 || e1) begin
            m_owner = e1;
            m_aluc  = e1 ? req1_aluc : req0_aluc;
            m_a     = e1 ? req1_a : req0_a;
            m_b     = e1 ? req1_b : req0_b;
            m_last  = e1;
            e.owner = e1;
            {e.r, e.f} = alu_f(m_aluc, m_a, m_b);
            exp_q.push_back(e);
            m_phase = 1; m_cnt = LAT;
          end
        end
        1: begin
          chk("issue_ctr", alu_ctr, 1);
          chk("issue_busy", busy, 1);
          chk("issue_ops", {alu_aluc, alu_a, alu_b}, {m_aluc, m_a, m_b});
          chk("issue_no_ready", {req0_ready, req1_ready}, 0);
          m_cnt--;
          if (m_cnt == 0) m_phase = 2;
        end
        default: begin
          chk("resp_ctr", alu_ctr, 0);
          chk("resp_busy", busy, 1);
          chk("resp_no_ready", {req0_ready, req1_ready}, 0);
          chk("resp_valids", {rsp1_valid, rsp0_valid}, m_owner ? 2'b10 : 2'b01);
          if (m_owner ? rsp1_ready : rsp0_ready) m_phase = 0;
        end
      endcase
    end
  end

  // Response monitor: checks whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rsp0_valid || rsp1_valid)) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {rsp1_valid, rsp0_valid}, 0);
      end else begin
        e = exp_q[0];
        chk("rsp_both", rsp0_valid & rsp1_valid, 0);
        chk("rsp_owner", rsp1_valid, e.owner);
        chk("rsp_r", e.owner ? rsp1_r : rsp0_r, e.r);
        chk("rsp_flags", e.owner ? rsp1_flags : rsp0_flags, e.f);
        if (e.owner ? rsp1_ready : rsp0_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_issue(input bit n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int t;
    if (n) begin req1_valid = 1'b1; req1_aluc = op; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1'b1; req0_aluc = op; req0_a = a; req0_b = b; end
    t = 0;
    @(negedge clk);
    while (!(n ? req1_ready : req0_ready) && t < 60) begin
      t++;
      @(negedge clk);
    end
    chk("issue_accepted_in_time", t < 60, 1);
    @(posedge clk); #1;
    if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    req0_valid = 0; req0_aluc = 0; req0_a = 0; req0_b = 0; rsp0_ready = 1;
    req1_valid = 0; req1_aluc = 0; req1_a = 0; req1_b = 0; rsp1_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_issue(1'b0, 4'b0000, 32'd5, 32'd7);
    do_issue(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1);
    do_issue(1'b0, 4'b1110, 32'd4, 32'd1);

    // Both requesters valid continuously.
    req0_valid = 1; req0_aluc = 4'b0000; req0_a = 32'd100; req0_b = 32'd23;
    req1_valid = 1; req1_aluc = 4'b0001; req1_a = 32'd100; req1_b = 32'd23;
    repeat (8 * (LAT + 2) + 2) @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    repeat (LAT + 3) @(posedge clk);
    #1;

    // Stalled consumer while the other requester waits.
    rsp0_ready = 0;
    do_issue(1'b0, 4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    req1_valid = 1; req1_aluc = 4'b0011; req1_a = 32'h8000_0000; req1_b = 32'd1;
    repeat (LAT + 6) @(posedge clk);
    #1 rsp0_ready = 1;
    t = 0;
    @(negedge clk);
    while (!req1_ready && t < 20) begin t++; @(negedge clk); end
    chk("bp_req1_granted", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 0;
    repeat (LAT + 3) @(posedge clk);
    #1;

    // Reset while the ALU op is in flight.
    do_issue(1'b1, 4'b0101, 32'd12, 32'd3);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req0_valid = 1; req0_aluc = 4'b0111; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1; req1_aluc = 4'b1011; req1_a = 32'hFFFF_FFFF; req1_b = 32'd0;
    @(negedge clk);
    chk("post_reset_tie_req0", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1 req0_valid = 0;
    repeat (LAT + 4) @(posedge clk);
    #1 req1_valid = 0;

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_aluc = 4'($urandom); req0_a = pick(); req0_b = pick();
      req1_aluc = 4'($urandom); req1_a = pick(); req1_b = pick();
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (LAT + 6) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("idle_at_end", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the execute stage, requester 1 is the branch/address-compare unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Requests are granted round-robin. Operands are latched, the ALU is driven with ctr=1 for ALU_LAT cycles, then result and flags are registered and returned to the granted requester.
- Sits between the pipeline control logic and the alu instance.

Parameters:
- WIDTH, 32, operand/result width; must be 32 to match the ALU.
- ALU_LAT, 1, cycles the ALU inputs are held with ctr=1 before capture; legal range 1..7.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle when valid&ready
- req0_aluc  in  4  ALU opcode (aluc encoding)
- req0_a  in  WIDTH  operand a
- req0_b  in  WIDTH  operand b
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_r  out  WIDTH  result
- rsp0_flags  out  4  {zero,carry,negative,overflow}
- req1_valid, req1_ready, req1_aluc, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_r, rsp1_flags: same as requester 0
- alu_ctr  out  1  ALU enable
- alu_aluc  out  4  opcode to ALU
- alu_a  out  WIDTH  operand a to ALU
- alu_b  out  WIDTH  operand b to ALU
- alu_r  in  WIDTH  ALU result
- alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each  ALU flags
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, last_grant=1 (requester 0 wins first tie).
  - lat_cnt=0; latched aluc/a/b=0; result and flag registers=0.
  - All *_ready, rsp*_valid, alu_ctr and busy = 0.
  - alu_a, alu_b and alu_aluc are driven from the latches, so they read 0.
- States are IDLE, ISSUE and RESP.
- IDLE:
  - If only reqN_valid is high, grant N.
  - If both are high, grant the requester not equal to last_grant.
  - reqN_ready is combinational: (state==IDLE) & (grant==N). At most one ready is high per cycle. No ready is high when neither valid is high.
  - On handshake: latch aluc/a/b and the owner index, set last_grant=N, lat_cnt=ALU_LAT-1, go to ISSUE.
- ISSUE:
  - alu_ctr=1; alu_aluc/alu_a/alu_b come from the latches and stay stable for the whole state.
  - Each cycle, decrement lat_cnt if it is nonzero.
  - When lat_cnt==0: capture alu_r and the four flags into registers at that edge, then go to RESP.
- RESP:
  - alu_ctr=0; rsp<owner>_valid=1, with rsp_r/flags from the capture registers held stable.
  - The other requester's rsp_valid=0.
  - When rsp<owner>_ready=1, go to IDLE next cycle. No new request is accepted in the same cycle.
- Timing for a handshake at cycle T:
  - ISSUE spans T+1..T+ALU_LAT.
  - rsp_valid first high at T+ALU_LAT+1.
  - Minimum spacing between accepts is ALU_LAT+2 cycles.
- alu_ctr is 0 in IDLE and RESP. The ALU latches its outputs when ctr=0, so captured values come only from ISSUE cycles.
- Backpressure: rsp_ready may stay low indefinitely. The FSM stays in RESP and the data does not change. A pending request on the other requester is not granted until the response is consumed.
- reqN_* may change while ready=0 without effect. Operands are sampled only at the handshake edge.
- All 16 aluc values are passed through unmodified; the arbiter does no decoding.
- Reset mid-operation (in ISSUE or RESP) drops the in-flight op: no response is produced, and after release the state is IDLE with last_grant=1.
- busy=1 in ISSUE and RESP.

Test Plan:
- Single op, ALU_LAT=1:
  - Stimulus: req0 aluc=0000, a=5, b=7, handshake at T; rsp0_ready held high.
  - Required: alu_ctr=1 at T+1 only; rsp0_valid at T+2 with r=12, flags=0000; IDLE at T+3.
- Tie, round-robin:
  - Stimulus: both valid continuously from reset.
  - Required: grants alternate 0,1,0,1; req0_ready first; each rsp goes only to its owner.
- Signed overflow, req1:
  - Stimulus: aluc=0010, a=0x7FFFFFFF, b=1.
  - Required: rsp1_r=0x80000000, flags=0011 (negative, overflow).
- Backpressure:
  - Stimulus: rsp0_ready low for 5 cycles, req1_valid high throughout.
  - Required: rsp0_valid and rsp0_r stable for 5 cycles; req1_ready stays 0 until the cycle after rsp0 consumption.
- ALU_LAT=3:
  - Stimulus: req0 aluc=1110 (sll), a=4, b=1.
  - Required: alu_ctr high for 3 consecutive cycles; rsp0_r=16 at T+4.
- Reset in ISSUE:
  - Stimulus: pulse rst_n low mid-ISSUE.
  - Required: outputs 0 immediately; no rsp; next tie grants requester 0.
